// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit: ID-stage hazard detection and stall/flush control for a
// five-stage MIPS pipeline. Inserts the stalls that the branch forwarding
// unit relies on and flushes IF/ID for taken branches and jumps.
//
// Optional statistics counters are enabled by defining BRANCH_HAZARD_STATS_EN.
module branch_hazard_unit #(
    parameter int LOAD_BRANCH_STALLS = 2,
    parameter int ALU_BRANCH_STALLS  = 1,
    parameter int LOAD_USE_STALLS    = 1,
    parameter int STAT_WIDTH         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            Branch,
    input  logic                  Jump,
    input  logic                  BranchTaken,
    input  logic [4:0]            IF_ID_RegisterRs,
    input  logic [4:0]            IF_ID_RegisterRt,
    input  logic                  ID_EX_RegWrite,
    input  logic                  ID_EX_MemRead,
    input  logic [4:0]            ID_EX_RegisterRd,
    input  logic                  EX_MEM_MemRead,
    input  logic [4:0]            EX_MEM_RegisterRd,
`ifdef BRANCH_HAZARD_STATS_EN
    output logic [STAT_WIDTH-1:0] StallCycles,
    output logic [STAT_WIDTH-1:0] FlushCount,
    output logic [STAT_WIDTH-1:0] HazardEvents,
`endif
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  ID_EX_Bubble,
    output logic                  IF_ID_Flush,
    output logic                  Stalling
);

    // The matchMEM case always needs exactly one stall, so 1 is a floor.
    localparam int MAX_AB = (LOAD_BRANCH_STALLS > ALU_BRANCH_STALLS) ?
                            LOAD_BRANCH_STALLS : ALU_BRANCH_STALLS;
    localparam int MAX_LU = (MAX_AB > LOAD_USE_STALLS) ? MAX_AB : LOAD_USE_STALLS;
    localparam int MAX_STALLS = (MAX_LU > 1) ? MAX_LU : 1;
    localparam int CNT_W = $clog2(MAX_STALLS + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   need_n;
    logic               is_branch;
    logic               match_ex;
    logic               match_mem;

    // Operand matches against EX and MEM producers; $0 never matches.
    always_comb begin
        is_branch = (Branch != 2'b00);
        match_ex  = ID_EX_RegWrite && (ID_EX_RegisterRd != 5'd0) &&
                    ((ID_EX_RegisterRd == IF_ID_RegisterRs) ||
                     (ID_EX_RegisterRd == IF_ID_RegisterRt));
        match_mem = EX_MEM_MemRead && (EX_MEM_RegisterRd != 5'd0) &&
                    ((EX_MEM_RegisterRd == IF_ID_RegisterRs) ||
                     (EX_MEM_RegisterRd == IF_ID_RegisterRt));
    end

    // Required stall length for the instruction currently in ID.
    always_comb begin
        need_n = '0;
        if (is_branch && match_ex && ID_EX_MemRead) begin
            need_n = CNT_W'(LOAD_BRANCH_STALLS);
        end else if (is_branch && match_ex) begin
            need_n = CNT_W'(ALU_BRANCH_STALLS);
        end else if (is_branch && match_mem) begin
            need_n = CNT_W'(1);
        end else if (!is_branch && match_ex && ID_EX_MemRead) begin
            need_n = CNT_W'(LOAD_USE_STALLS);
        end
    end

    // Next-state and pipeline control; stall overrides flush, reset overrides all.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        Stalling     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (need_n != '0) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    Stalling     = 1'b1;
                    if (need_n > CNT_W'(1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = need_n - CNT_W'(1);
                    end
                end else begin
                    IF_ID_Flush = (is_branch && BranchTaken) || Jump;
                end
            end
            ST_HOLD: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
                Stalling     = 1'b1;
                cnt_d        = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        if (!rst_n) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            IF_ID_Flush  = 1'b0;
            Stalling     = 1'b0;
        end
    end

    // State and remaining-stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BRANCH_HAZARD_STATS_EN
    logic [STAT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [STAT_WIDTH-1:0] flush_count_q, flush_count_d;
    logic [STAT_WIDTH-1:0] hazard_events_q, hazard_events_d;
    logic                  hazard_event;

    // Saturating event counters.
    always_comb begin
        hazard_event    = (state_q == ST_RUN) && (need_n != '0);
        stall_cycles_d  = stall_cycles_q;
        flush_count_d   = flush_count_q;
        hazard_events_d = hazard_events_q;
        if (Stalling && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (IF_ID_Flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
        if (hazard_event && (hazard_events_q != '1)) begin
            hazard_events_d = hazard_events_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
            hazard_events_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
            hazard_events_q <= hazard_events_d;
        end
    end

    assign StallCycles  = stall_cycles_q;
    assign FlushCount   = flush_count_q;
    assign HazardEvents = hazard_events_q;
`endif

endmodule
